div: RTL

- Multi-cycle radix-2 restoring integer divider for the execute stage; the inverse counterpart of the shift-add multiplier.
- Uses the same start/cancel/stop handshake as the multiplier.
- Serves RISC-V DIV/DIVU/REM/REMU: one start pulse in, quotient and remainder out with a one-cycle stop pulse.
- The execute stage stalls the pipeline while busy is high.

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_if.sv | 26 ++
 rtl/div_neg.sv | 12 +
 rtl/div.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared bus width and divider state encodings
package div_pkg;

  localparam int REG_BUS_WIDTH        = 32;
  localparam int DOUBLE_REG_BUS_WIDTH = 2 * REG_BUS_WIDTH;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  // Most negative two's-complement value of a given width, the only signed dividend that can overflow.
  function automatic logic [DOUBLE_REG_BUS_WIDTH-1:0] min_neg(input int width);
    logic [DOUBLE_REG_BUS_WIDTH-1:0] v;
    v = '0;
    v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/div_if.sv
// rtl/div_if.sv - start/cancel/stop handshake and operand/result bus of the divider
interface div_if import div_pkg::*; #(
  parameter int WIDTH = REG_BUS_WIDTH
);

  logic             div_start_i;
  logic             div_cancel_i;
  logic             div_signed_i;
  logic [WIDTH-1:0] div_op1_i;
  logic [WIDTH-1:0] div_op2_i;
  logic             div_busy_o;
  logic             div_stop_o;
  logic [WIDTH-1:0] div_quot_o;
  logic [WIDTH-1:0] div_rem_o;

  modport master (
    output div_start_i, div_cancel_i, div_signed_i, div_op1_i, div_op2_i,
    input  div_busy_o, div_stop_o, div_quot_o, div_rem_o
  );

  modport slave (
    input  div_start_i, div_cancel_i, div_signed_i, div_op1_i, div_op2_i,
    output div_busy_o, div_stop_o, div_quot_o, div_rem_o
  );

endinterface

// File: rtl/div_neg.sv
// rtl/div_neg.sv - conditional two's-complement negate
module div_neg import div_pkg::*; #(
  parameter int WIDTH = REG_BUS_WIDTH
) (
  input  logic             neg_i,
  input  logic [WIDTH-1:0] val_i,
  output logic [WIDTH-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/div.sv
// rtl/div.sv - multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU
module div import div_pkg::*; #(
  parameter int WIDTH = REG_BUS_WIDTH
) (
  input logic  clk,
  input logic  rst_n,
  div_if.slave bus
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = min_neg(WIDTH)[WIDTH-1:0];

  div_state_e       state_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] rem_acc_q;
  logic [WIDTH-1:0] quot_shift_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             neg_quot_q;
  logic             neg_rem_q;
  logic             busy_q;
  logic             stop_q;

  logic             op1_neg;
  logic             op2_neg;
  logic [WIDTH-1:0] op1_abs;
  logic [WIDTH-1:0] op2_abs;
  logic             div_zero;
  logic             div_ovf;
  logic             dvd_zero;
  logic [WIDTH:0]   trial_d;
  logic [WIDTH-1:0] rem_acc_d;
  logic [WIDTH-1:0] quot_shift_d;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  assign op1_neg = bus.div_signed_i & bus.div_op1_i[WIDTH-1];
  assign op2_neg = bus.div_signed_i & bus.div_op2_i[WIDTH-1];

  div_neg #(.WIDTH(WIDTH)) u_abs_op1 (.neg_i(op1_neg), .val_i(bus.div_op1_i), .val_o(op1_abs));
  div_neg #(.WIDTH(WIDTH)) u_abs_op2 (.neg_i(op2_neg), .val_i(bus.div_op2_i), .val_o(op2_abs));

  assign div_zero = (bus.div_op2_i == '0);
  assign div_ovf  = bus.div_signed_i && (bus.div_op1_i == MIN_NEG) && (bus.div_op2_i == '1);
  assign dvd_zero = (bus.div_op1_i == '0);

  // The partial remainder is always below the divisor, so the full remainder is shifted in
  // and a set borrow bit in the WIDTH+1 result means the trial subtraction went negative.
  assign trial_d      = {rem_acc_q, quot_shift_q[WIDTH-1]} - {1'b0, divisor_q};
  assign rem_acc_d    = trial_d[WIDTH] ? {rem_acc_q[WIDTH-2:0], quot_shift_q[WIDTH-1]}
                                       : trial_d[WIDTH-1:0];
  assign quot_shift_d = {quot_shift_q[WIDTH-2:0], ~trial_d[WIDTH]};

  div_neg #(.WIDTH(WIDTH)) u_fix_quot (.neg_i(neg_quot_q), .val_i(quot_shift_d), .val_o(quot_fix));
  div_neg #(.WIDTH(WIDTH)) u_fix_rem  (.neg_i(neg_rem_q),  .val_i(rem_acc_d),    .val_o(rem_fix));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= DIV_IDLE;
      count_q      <= '0;
      divisor_q    <= '0;
      rem_acc_q    <= '0;
      quot_shift_q <= '0;
      quot_q       <= '0;
      rem_q        <= '0;
      neg_quot_q   <= 1'b0;
      neg_rem_q    <= 1'b0;
      busy_q       <= 1'b0;
      stop_q       <= 1'b0;
    end else if (bus.div_cancel_i) begin
      state_q <= DIV_IDLE;
      count_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          stop_q <= 1'b0;
          if (bus.div_start_i) begin
            divisor_q    <= op2_abs;
            neg_quot_q   <= bus.div_signed_i & (bus.div_op1_i[WIDTH-1] ^ bus.div_op2_i[WIDTH-1]);
            neg_rem_q    <= op1_neg;
            count_q      <= '0;
            rem_acc_q    <= '0;
            quot_shift_q <= op1_abs;
            busy_q       <= 1'b1;
            if (div_zero) begin
              state_q <= DIV_DONE;
              stop_q  <= 1'b1;
              quot_q  <= '1;
              rem_q   <= bus.div_op1_i;
            end else if (div_ovf) begin
              state_q <= DIV_DONE;
              stop_q  <= 1'b1;
              quot_q  <= bus.div_op1_i;
              rem_q   <= '0;
            end else if (dvd_zero) begin
              state_q <= DIV_DONE;
              stop_q  <= 1'b1;
              quot_q  <= '0;
              rem_q   <= '0;
            end else begin
              state_q <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          count_q      <= count_q + CNT_W'(1);
          rem_acc_q    <= rem_acc_d;
          quot_shift_q <= quot_shift_d;
          if (count_q == LAST_CNT) begin
            state_q <= DIV_DONE;
            stop_q  <= 1'b1;
            quot_q  <= quot_fix;
            rem_q   <= rem_fix;
          end
        end
        DIV_DONE: begin
          state_q <= DIV_IDLE;
          busy_q  <= 1'b0;
          stop_q  <= 1'b0;
        end
        default: begin
          state_q <= DIV_IDLE;
          busy_q  <= 1'b0;
          stop_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.div_busy_o = busy_q;
  assign bus.div_stop_o = stop_q;
  assign bus.div_quot_o = quot_q;
  assign bus.div_rem_o  = rem_q;

endmodule
